// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-master SDRAM port arbiter: default
// geometry of the 32M x 16 SDRAM port, arbiter state encoding, master ids
// and the round-robin pick helper.
package sdram_arb_pkg;

    localparam int DEF_ADDR_W   = 25;  // word address, 32M halfwords
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_BE_W     = DEF_DATA_W / 8;
    localparam int DEF_MAX_PEND = 8;   // outstanding reads, power of 2

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Master ids double as the tag stored per outstanding read.
    localparam logic M_VIDEO = 1'b0;
    localparam logic M_CPU   = 1'b1;

    // Round-robin choice between two masters. Only meaningful when at least
    // one is eligible; with both eligible the one not served last wins.
    function automatic logic rr_pick(input logic elig0,
                                     input logic elig1,
                                     input logic last_grant);
        if (elig0 && elig1) begin
            return ~last_grant;
        end else if (elig1) begin
            return M_CPU;
        end else begin
            return M_VIDEO;
        end
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_tag_fifo.sv
// Pending-read tag FIFO: one bit per outstanding read naming the master
// that issued it. Power-of-2 depth lets the pointers wrap naturally.
// Head tag is presented combinationally so the read-return strobe can be
// steered in the same cycle the controller returns data.
module tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_PEND
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     tag_i,
    input  logic                     pop_i,
    output logic                     head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // allowed when a pop frees the head slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Tag storage written at the tail.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the pointers and count
        // define which entries are valid, so stale contents are never read.
        if (do_push) begin
            mem_q[wr_ptr_q] <= tag_i;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller slave.
// Master 0 is the video line-buffer fetch, master 1 the CPU bridge.
// Round-robin grant, one single-word transfer at a time, pipelined reads
// whose returns are steered back via a tag FIFO of issuing-master ids.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BE_W     = DEF_BE_W,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                       Clk,
    input  logic                       Reset,

    // Master 0 (video)
    input  logic [ADDR_W-1:0]          m0_address,
    input  logic                       m0_read,
    input  logic                       m0_write,
    input  logic [DATA_W-1:0]          m0_writedata,
    input  logic [BE_W-1:0]            m0_byteenable,
    output logic                       m0_waitrequest,
    output logic [DATA_W-1:0]          m0_readdata,
    output logic                       m0_readdatavalid,

    // Master 1 (CPU)
    input  logic [ADDR_W-1:0]          m1_address,
    input  logic                       m1_read,
    input  logic                       m1_write,
    input  logic [DATA_W-1:0]          m1_writedata,
    input  logic [BE_W-1:0]            m1_byteenable,
    output logic                       m1_waitrequest,
    output logic [DATA_W-1:0]          m1_readdata,
    output logic                       m1_readdatavalid,

    // SDRAM controller slave
    output logic [ADDR_W-1:0]          s_address,
    output logic                       s_read,
    output logic                       s_write,
    output logic [DATA_W-1:0]          s_writedata,
    output logic [BE_W-1:0]            s_byteenable,
    input  logic                       s_waitrequest,
    input  logic [DATA_W-1:0]          s_readdata,
    input  logic                       s_readdatavalid,

    // Status
    output logic [$clog2(MAX_PEND):0]  pend_count,
    output logic                       err_orphan
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       err_orphan_q;

    logic       elig0;
    logic       elig1;
    logic       accept;
    logic       fifo_push;
    logic       fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       ret_valid;

    // A read is only eligible while there is room to remember its tag;
    // the registered count is used, so a same-cycle return does not help.
    assign elig0 = m0_write | (m0_read & ~fifo_full);
    assign elig1 = m1_write | (m1_read & ~fifo_full);

    // The controller takes the granted request on any BUSY cycle without
    // waitrequest; the bus then returns to IDLE for re-arbitration.
    assign accept    = (state_q == BUSY) & ~s_waitrequest;
    assign fifo_push = accept & s_read;

    // Next-state logic for the grant FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_d = BUSY;
                    grant_d = rr_pick(elig0, elig1, last_grant_q);
                end
            end
            BUSY: begin
                if (!s_waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant FSM registers; last_grant resets to the CPU so the video
    // master wins the first contested arbitration.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            grant_q      <= M_VIDEO;
            last_grant_q <= M_CPU;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Forward the granted master's request to the slave; idle bus is all-zero.
    always_comb begin
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        if (state_q == BUSY) begin
            if (grant_q == M_CPU) begin
                s_read       = m1_read;
                s_write      = m1_write;
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
            end else begin
                s_read       = m0_read;
                s_write      = m0_write;
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
            end
        end
    end

    // Each master is released only in the cycle its own request is taken.
    assign m0_waitrequest = ~(accept && (grant_q == M_VIDEO));
    assign m1_waitrequest = ~(accept && (grant_q == M_CPU));

    tag_fifo #(
        .DEPTH   (MAX_PEND)
    ) u_tag_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (fifo_push),
        .tag_i   (grant_q),
        .pop_i   (s_readdatavalid),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pend_count)
    );

    // Read data is broadcast; only the valid strobe follows the head tag.
    assign ret_valid        = s_readdatavalid & ~fifo_empty;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = ret_valid && (fifo_head == M_VIDEO);
    assign m1_readdatavalid = ret_valid && (fifo_head == M_CPU);

    // Sticky flag for returns with no outstanding read to match them to.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_orphan_q <= 1'b0;
        end else if (s_readdatavalid && fifo_empty) begin
            err_orphan_q <= 1'b1;
        end
    end

    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios followed by a random
// two-master / stalling-slave run checked against a transaction-level model.
module tb_sdram_port_arbiter;

    localparam int ADDR_W   = 25;
    localparam int DATA_W   = 16;
    localparam int BE_W     = 2;
    localparam int MAX_PEND = 8;
    localparam int CW       = $clog2(MAX_PEND) + 1;

    logic              Clk;
    logic              Reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic [CW-1:0]     pend_count;
    logic              err_orphan;

    int checks = 0;
    int errors = 0;

    sdram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BE_W     (BE_W),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .pend_count       (pend_count),
        .err_orphan       (err_orphan)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case something below never returns.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    endtask

    // Reference model for the random phase: each master's outstanding
    // request, and the in-order list of reads the slave still owes.
    typedef struct {
        bit                active;
        bit                is_read;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        int                waited;
    } req_t;

    typedef struct {
        int                master;
        logic [DATA_W-1:0] data;
    } ret_t;

    req_t req[2];
    ret_t ret_q[$];

    task automatic drive_masters();
        m0_read       = req[0].active & req[0].is_read;
        m0_write      = req[0].active & ~req[0].is_read;
        m0_address    = req[0].addr;
        m0_writedata  = req[0].wdata;
        m0_byteenable = req[0].be;
        m1_read       = req[1].active & req[1].is_read;
        m1_write      = req[1].active & ~req[1].is_read;
        m1_address    = req[1].addr;
        m1_writedata  = req[1].wdata;
        m1_byteenable = req[1].be;
    endtask

    initial begin
        bit                exp_valid;
        int                exp_m;
        bit                prev_acc;
        bit                any_acc;
        logic              wr_n[2];
        logic [ADDR_W-1:0] a;

        idle_inputs();
        Reset = 1'b1;

        // ---- Reset state ----
        tick(); tick(); settle();
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
        chk("rst_s_req",   32'({s_read, s_write}), 32'h0);
        chk("rst_rdv",     32'({m0_readdatavalid, m1_readdatavalid}), 32'h0);
        chk("rst_pend",    32'(pend_count), 32'h0);
        chk("rst_orphan",  32'(err_orphan), 32'h0);
        Reset = 1'b0;
        tick();

        // ---- Single m1 write ----
        m1_write = 1'b1; m1_address = 25'h0001234; m1_writedata = 16'hBEEF; m1_byteenable = 2'b11;
        settle();
        chk("wr_idle_s_write", 32'(s_write), 32'h0);
        chk("wr_idle_m1_wait", 32'(m1_waitrequest), 32'h1);
        tick(); settle();
        chk("wr_s_write", 32'(s_write), 32'h1);
        chk("wr_s_addr",  32'(s_address), 32'h0001234);
        chk("wr_s_data",  32'(s_writedata), 32'hBEEF);
        chk("wr_s_be",    32'(s_byteenable), 32'h3);
        chk("wr_m1_wait", 32'(m1_waitrequest), 32'h0);
        chk("wr_m0_wait", 32'(m0_waitrequest), 32'h1);
        tick();
        m1_write = 1'b0;
        settle();
        chk("wr_done_s_write", 32'(s_write), 32'h0);
        chk("wr_done_pend",    32'(pend_count), 32'h0);

        // ---- Simultaneous reads: m0 first, then m1; returns steered ----
        m0_read = 1'b1; m0_address = 25'h0000100;
        m1_read = 1'b1; m1_address = 25'h0000200;
        tick(); settle();
        chk("rr_first_s_read", 32'(s_read), 32'h1);
        chk("rr_first_addr",   32'(s_address), 32'h0000100);
        chk("rr_first_m0_wait", 32'(m0_waitrequest), 32'h0);
        chk("rr_first_m1_wait", 32'(m1_waitrequest), 32'h1);
        tick();
        m0_read = 1'b0;
        settle();
        chk("rr_gap_s_read", 32'(s_read), 32'h0);
        chk("rr_gap_pend",   32'(pend_count), 32'h1);
        tick(); settle();
        chk("rr_second_addr",    32'(s_address), 32'h0000200);
        chk("rr_second_m1_wait", 32'(m1_waitrequest), 32'h0);
        tick();
        m1_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 16'h1111;
        settle();
        chk("rr_ret0_m0_rdv", 32'(m0_readdatavalid), 32'h1);
        chk("rr_ret0_m1_rdv", 32'(m1_readdatavalid), 32'h0);
        chk("rr_ret0_data",   32'(m0_readdata), 32'h1111);
        chk("rr_ret0_pend",   32'(pend_count), 32'h2);
        tick();
        s_readdata = 16'h2222;
        settle();
        chk("rr_ret1_m1_rdv", 32'(m1_readdatavalid), 32'h1);
        chk("rr_ret1_m0_rdv", 32'(m0_readdatavalid), 32'h0);
        chk("rr_ret1_data",   32'(m1_readdata), 32'h2222);
        chk("rr_ret1_pend",   32'(pend_count), 32'h1);
        tick();
        s_readdatavalid = 1'b0;
        settle();
        chk("rr_drained_pend", 32'(pend_count), 32'h0);

        // ---- Slave stalls an m0 write for 5 cycles; m1 waits ----
        m0_write = 1'b1; m0_address = 25'h1ABCDEF; m0_writedata = 16'hCAFE; m0_byteenable = 2'b01;
        m1_write = 1'b1; m1_address = 25'h0000042; m1_writedata = 16'h1234; m1_byteenable = 2'b10;
        s_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_s_write", 32'(s_write), 32'h1);
            chk("stall_addr",    32'(s_address), 32'h1ABCDEF);
            chk("stall_data",    32'(s_writedata), 32'hCAFE);
            chk("stall_be",      32'(s_byteenable), 32'h1);
            chk("stall_waits",   32'({m0_waitrequest, m1_waitrequest}), 32'h3);
            tick();
        end
        s_waitrequest = 1'b0;
        settle();
        chk("stall_accept_m0_wait", 32'(m0_waitrequest), 32'h0);
        chk("stall_accept_addr",    32'(s_address), 32'h1ABCDEF);
        tick();
        m0_write = 1'b0;
        settle();
        chk("stall_gap_s_write", 32'(s_write), 32'h0);
        chk("stall_gap_m1_wait", 32'(m1_waitrequest), 32'h1);
        tick(); settle();
        chk("stall_m1_addr", 32'(s_address), 32'h0000042);
        chk("stall_m1_data", 32'(s_writedata), 32'h1234);
        chk("stall_m1_wait", 32'(m1_waitrequest), 32'h0);
        tick();
        m1_write = 1'b0;

        // ---- Fill the tag FIFO with m0 reads; writes still pass ----
        for (int i = 0; i < MAX_PEND; i++) begin
            m0_read = 1'b1; m0_address = ADDR_W'(32'h300 + 32'(i));
            tick(); settle();
            chk("fill_m0_wait", 32'(m0_waitrequest), 32'h0);
            chk("fill_addr",    32'(s_address), 32'h300 + 32'(i));
            tick();
        end
        m0_address = 25'h0000308;
        m1_write = 1'b1; m1_address = 25'h0000400; m1_writedata = 16'h9999; m1_byteenable = 2'b11;
        settle();
        chk("full_pend", 32'(pend_count), 32'(MAX_PEND));
        tick(); settle();
        chk("full_wr_s_write", 32'(s_write), 32'h1);
        chk("full_wr_s_read",  32'(s_read), 32'h0);
        chk("full_wr_m1_wait", 32'(m1_waitrequest), 32'h0);
        chk("full_wr_m0_wait", 32'(m0_waitrequest), 32'h1);
        tick();
        m1_write = 1'b0;
        tick(); settle();
        chk("full_rd_blocked_s_read", 32'(s_read), 32'h0);
        chk("full_rd_blocked_m0_wait", 32'(m0_waitrequest), 32'h1);
        s_readdatavalid = 1'b1; s_readdata = 16'h5555;
        settle();
        chk("full_ret_m0_rdv", 32'(m0_readdatavalid), 32'h1);
        tick();
        s_readdatavalid = 1'b0;
        settle();
        chk("full_pop_s_read", 32'(s_read), 32'h0);
        chk("full_pop_pend",   32'(pend_count), 32'(MAX_PEND - 1));
        tick(); settle();
        chk("full_regrant_s_read",  32'(s_read), 32'h1);
        chk("full_regrant_addr",    32'(s_address), 32'h0000308);
        chk("full_regrant_m0_wait", 32'(m0_waitrequest), 32'h0);
        tick();
        m0_read = 1'b0;
        settle();
        chk("full_again_pend", 32'(pend_count), 32'(MAX_PEND));
        for (int i = 0; i < MAX_PEND - 3; i++) begin
            s_readdatavalid = 1'b1; s_readdata = DATA_W'(32'h6000 + 32'(i));
            settle();
            chk("drain5_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'h2);
            tick();
        end
        s_readdatavalid = 1'b0;
        settle();
        chk("drain5_pend", 32'(pend_count), 32'h3);

        // ---- Push and pop in the same cycle at pend_count=3 ----
        m1_read = 1'b1; m1_address = 25'h0000500;
        tick();
        s_readdatavalid = 1'b1; s_readdata = 16'h7777;
        settle();
        chk("pp_m1_wait", 32'(m1_waitrequest), 32'h0);
        chk("pp_m0_rdv",  32'(m0_readdatavalid), 32'h1);
        chk("pp_m1_rdv",  32'(m1_readdatavalid), 32'h0);
        chk("pp_data",    32'(m0_readdata), 32'h7777);
        chk("pp_pend_before", 32'(pend_count), 32'h3);
        tick();
        m1_read = 1'b0; s_readdatavalid = 1'b0;
        settle();
        chk("pp_pend_after", 32'(pend_count), 32'h3);
        for (int i = 0; i < 3; i++) begin
            s_readdatavalid = 1'b1; s_readdata = DATA_W'(32'h8000 + 32'(i));
            settle();
            chk("pp_order_m0_rdv", 32'(m0_readdatavalid), 32'(i < 2));
            chk("pp_order_m1_rdv", 32'(m1_readdatavalid), 32'(i == 2));
            tick();
        end
        s_readdatavalid = 1'b0;
        settle();
        chk("pp_final_pend", 32'(pend_count), 32'h0);

        // ---- Reset with reads in flight, then a stale return ----
        for (int i = 0; i < 2; i++) begin
            m0_read = 1'b1; m0_address = ADDR_W'(32'h600 + 32'(i));
            tick(); settle();
            chk("rstfl_m0_wait", 32'(m0_waitrequest), 32'h0);
            tick();
        end
        m0_read = 1'b0;
        settle();
        chk("rstfl_pend_before", 32'(pend_count), 32'h2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        settle();
        chk("rstfl_pend_flushed", 32'(pend_count), 32'h0);
        chk("rstfl_orphan_clear", 32'(err_orphan), 32'h0);
        s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
        settle();
        chk("rstfl_no_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'h0);
        tick();
        s_readdatavalid = 1'b0;
        settle();
        chk("rstfl_orphan_set", 32'(err_orphan), 32'h1);
        repeat (3) tick();
        settle();
        chk("rstfl_orphan_sticky", 32'(err_orphan), 32'h1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        settle();
        chk("rstfl_orphan_reset", 32'(err_orphan), 32'h0);

        // ---- Random traffic against the transaction-level model ----
        idle_inputs();
        for (int n = 0; n < 2; n++) begin
            req[n].active = 1'b0; req[n].is_read = 1'b0;
            req[n].addr = '0; req[n].wdata = '0; req[n].be = '0; req[n].waited = 0;
        end
        prev_acc = 1'b0;
        tick();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc >= 3000 && !req[0].active && !req[1].active && ret_q.size() == 0) break;
            // Masters: start a new request only when the previous one is done.
            for (int n = 0; n < 2; n++) begin
                if (!req[n].active && cyc < 3000 && $urandom_range(0, 2) != 0) begin
                    a = ADDR_W'($urandom);
                    req[n].active  = 1'b1;
                    req[n].is_read = ($urandom_range(0, 2) != 0);
                    req[n].addr    = a;
                    req[n].wdata   = DATA_W'($urandom);
                    req[n].be      = BE_W'($urandom);
                    req[n].waited  = 0;
                end
            end
            drive_masters();
            // Slave: random stalls, in-order returns of earlier accepted reads.
            s_waitrequest = ($urandom_range(0, 3) == 0);
            exp_valid = 1'b0;
            exp_m = 0;
            if (ret_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                exp_valid = 1'b1;
                exp_m = ret_q[0].master;
                s_readdatavalid = 1'b1;
                s_readdata = ret_q[0].data;
            end else begin
                s_readdatavalid = 1'b0;
                s_readdata = DATA_W'($urandom);
            end
            settle();

            chk("rnd_pend", 32'(pend_count), 32'(ret_q.size()));
            chk("rnd_orphan", 32'(err_orphan), 32'h0);
            chk("rnd_rdv0", 32'(m0_readdatavalid), 32'(exp_valid && exp_m == 0));
            chk("rnd_rdv1", 32'(m1_readdatavalid), 32'(exp_valid && exp_m == 1));
            if (exp_valid) begin
                chk("rnd_rdata", 32'((exp_m == 0) ? m0_readdata : m1_readdata), 32'(ret_q[0].data));
                void'(ret_q.pop_front());
            end

            wr_n[0] = m0_waitrequest;
            wr_n[1] = m1_waitrequest;
            chk("rnd_one_grant", 32'(wr_n[0] | wr_n[1]), 32'h1);
            any_acc = 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (!wr_n[n]) begin
                    chk("rnd_acc_active", 32'(req[n].active), 32'h1);
                    chk("rnd_s_read",  32'(s_read),  32'(req[n].is_read));
                    chk("rnd_s_write", 32'(s_write), 32'(!req[n].is_read));
                    chk("rnd_s_addr",  32'(s_address), 32'(req[n].addr));
                    chk("rnd_s_data",  32'(s_writedata), 32'(req[n].wdata));
                    chk("rnd_s_be",    32'(s_byteenable), 32'(req[n].be));
                    chk("rnd_throughput", 32'(prev_acc), 32'h0);
                    chk("rnd_latency", 32'(req[n].waited <= 200), 32'h1);
                    if (req[n].is_read) begin
                        ret_q.push_back('{master: n, data: DATA_W'($urandom)});
                    end
                    req[n].active = 1'b0;
                    any_acc = 1'b1;
                end else if (req[n].active) begin
                    req[n].waited++;
                end
            end
            prev_acc = any_acc;
            tick();
        end
        idle_inputs();
        settle();
        chk("rnd_drained", 32'(!req[0].active && !req[1].active && ret_q.size() == 0), 32'h1);
        chk("rnd_final_pend", 32'(pend_count), 32'h0);
        chk("rnd_final_orphan", 32'(err_orphan), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-master Avalon-MM arbiter in front of the SoC SDRAM controller slave (32M x 16 part, 13-bit row / 2-bit bank / 10-bit column).
- Shares the single SDRAM port between master 0 (video/line-buffer fetch) and master 1 (CPU-side bridge).
- Round-robin grant, single-word transfers, pipelined reads.
- A pending-read tag FIFO routes each readdatavalid back to the master that issued the read.

Parameters:
- ADDR_W, 25, word address width (32M halfwords)
- DATA_W, 16, data width
- BE_W, 2, byteenable width (DATA_W/8)
- MAX_PEND, 8, max outstanding reads (power of 2, >=2)

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- mN_address  in  ADDR_W  master N word address (N = 0, 1; same for all mN_* below).
- mN_read, mN_write  in  1 each  requests; mutually exclusive per master.
- mN_writedata  in  DATA_W  write data.
- mN_byteenable  in  BE_W  byte enables.
- mN_waitrequest  out  1  stall to master N.
- mN_readdata  out  DATA_W  read data, valid with mN_readdatavalid.
- mN_readdatavalid  out  1  one-cycle read-return strobe.
- s_address  out  ADDR_W  to SDRAM controller.
- s_read, s_write  out  1 each  to SDRAM controller.
- s_writedata  out  DATA_W  to SDRAM controller.
- s_byteenable  out  BE_W  to SDRAM controller.
- s_waitrequest  in  1  from SDRAM controller.
- s_readdata  in  DATA_W  from SDRAM controller.
- s_readdatavalid  in  1  from SDRAM controller.
- pend_count  out  $clog2(MAX_PEND)+1  outstanding reads (registered).
- err_orphan  out  1  sticky: readdatavalid arrived with tag FIFO empty.

Behaviour:
- State machine, states IDLE and BUSY. Registers: grant (1 b), last_grant (1 b), tag FIFO, err_orphan.
- Reset: state=IDLE, last_grant=1, FIFO empty, pend_count=0, err_orphan=0. All s_* request outputs 0; mN_readdatavalid 0; mN_waitrequest 1.
- Eligibility: master N is eligible if mN_write=1, or mN_read=1 and pend_count<MAX_PEND. Use the registered count; a same-cycle pop does not make a read eligible.
- IDLE:
  - No eligible master: stay in IDLE.
  - One eligible master: grant<=N, go to BUSY.
  - Both eligible: grant<=~last_grant, go to BUSY.
  - Arbitration latency is 1 cycle.
- BUSY:
  - s_* request outputs = the granted master's signals, combinationally.
  - If s_waitrequest=0, the transfer is accepted: last_grant<=grant, go to IDLE, and push grant into the FIFO if it was a read.
  - If s_waitrequest=1, hold state and grant.
- Outside BUSY: s_read=s_write=0, s_address/s_writedata/s_byteenable=0.
- mN_waitrequest = ~(state==BUSY && grant==N && s_waitrequest==0).
- Masters follow Avalon rules and hold their request until waitrequest=0. The arbiter does not sample again mid-transfer.
- Throughput: at most 1 accepted transfer per 2 cycles.
- Read return: on s_readdatavalid=1 with FIFO non-empty:
  - head tag H selects the master; mH_readdatavalid=1 combinationally, same cycle, 0-cycle added latency.
  - pop the FIFO.
- mN_readdata = s_readdata for both masters; only the valid strobe is steered.
- s_readdatavalid with FIFO empty: no master strobe; err_orphan<=1 until Reset.
- Simultaneous push and pop: pend_count unchanged; data ordering preserved (in-order SDRAM returns).
- Full FIFO: reads ineligible, writes still granted. Write traffic never starves on outstanding reads.
- Reset mid-operation: FIFO is flushed. Read data still in flight from the controller after Reset is dropped and sets err_orphan. Integration must reset the controller together with this block.

Decomposition:
- Package sdram_arb_pkg: ADDR_W/DATA_W/BE_W defaults, state enum {IDLE, BUSY}, master-id constants M_VIDEO=0, M_CPU=1.
- One sub-module: tag_fifo. 1-bit wide, MAX_PEND deep, synchronous push/pop, full/empty/count outputs, pointer wrap by power-of-2 width.

Test Plan:
- Single write m1 (addr 0x0001234, data 0xBEEF, be 2'b11), s_waitrequest low → s_write pulse 1 cycle after request with those values; m1_waitrequest low in that cycle; pend_count stays 0.
- Both masters read in the same cycle after reset → m0 granted first, then m1. Controller returns 0x1111, 0x2222 → m0_readdatavalid with 0x1111, then m1_readdatavalid with 0x2222.
- Controller holds s_waitrequest=1 for 5 cycles during m0 write → s_* outputs stable all 5 cycles; m1 request not granted until m0 accepted.
- m0 issues 8 reads, no returns → pend_count=8. Ninth m0 read stalls (waitrequest=1) while an m1 write proceeds. One return → next read granted the cycle after.
- Return and new read acceptance in the same cycle at pend_count=3 → pend_count stays 3; tags delivered in issue order.
- Reset asserted with 2 reads pending, then controller emits readdatavalid → no mN_readdatavalid; err_orphan=1 and held until next Reset.
